// File: rtl/sram_bus_arbiter_pkg.sv
// Shared bus definitions for the SRAM arbiter: widths, FSM states and owner encoding.
package cpu_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWNER_DATA = 1'b0,
        OWNER_INST = 1'b1
    } owner_t;

endpackage

// File: rtl/sram_bus_arbiter_if.sv
// One SRAM-style request/response channel; used for both requesters and the memory port.
interface sram_bus_arbiter_if;
    import cpu_bus_pkg::*;

    logic              req;
    logic              wr;
    logic [STRB_W-1:0] wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;

    // Master issues requests; slave accepts them and returns responses.
    modport master (
        output req, wr, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/sram_bus_arbiter.sv
// Two-requester (inst/data) arbiter onto one SRAM-style memory port, one transaction in flight.
module sram_bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    sram_bus_arbiter_if.slave   inst,
    sram_bus_arbiter_if.slave   data,
    sram_bus_arbiter_if.master  mem
);

    localparam int                CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_LIMIT);

    state_t             state, state_nx;
    owner_t             owner, owner_nx;
    logic [CNT_W-1:0]   starve_cnt, starve_cnt_nx;
    logic               grant_inst;
    logic               bus_addr_ok;
    logic               bus_data_ok;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= OWNER_DATA;
            starve_cnt <= '0;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            starve_cnt <= starve_cnt_nx;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nx      = state;
        owner_nx      = owner;
        starve_cnt_nx = starve_cnt;
        grant_inst    = inst.req && (!data.req || (starve_cnt == CNT_MAX));

        unique case (state)
            IDLE: begin
                if (inst.req || data.req) begin
                    state_nx = REQ;
                    if (grant_inst) begin
                        owner_nx      = OWNER_INST;
                        starve_cnt_nx = '0;
                    end else begin
                        owner_nx = OWNER_DATA;
                        // Count data grants only while inst is actually waiting.
                        if (!inst.req)
                            starve_cnt_nx = '0;
                        else if (starve_cnt != CNT_MAX)
                            starve_cnt_nx = starve_cnt + 1'b1;
                    end
                end
            end
            REQ: begin
                if (mem.addr_ok)
                    state_nx = mem.data_ok ? IDLE : RESP;
            end
            RESP: begin
                if (mem.data_ok)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        mem.req      = 1'b0;
        mem.wr       = 1'b0;
        mem.wstrb    = '0;
        mem.addr     = '0;
        mem.wdata    = '0;
        bus_addr_ok  = 1'b0;
        bus_data_ok  = 1'b0;

        // Handshake outputs are held low for the whole reset cycle, not just after it.
        if (!reset) begin
            unique case (state)
                REQ: begin
                    mem.req     = 1'b1;
                    mem.wr      = (owner == OWNER_INST) ? inst.wr    : data.wr;
                    mem.wstrb   = (owner == OWNER_INST) ? inst.wstrb : data.wstrb;
                    mem.addr    = (owner == OWNER_INST) ? inst.addr  : data.addr;
                    mem.wdata   = (owner == OWNER_INST) ? inst.wdata : data.wdata;
                    bus_addr_ok = mem.addr_ok;
                    bus_data_ok = mem.addr_ok && mem.data_ok;
                end
                RESP: begin
                    bus_data_ok = mem.data_ok;
                end
                default: ;
            endcase
        end

        inst.addr_ok = bus_addr_ok && (owner == OWNER_INST);
        inst.data_ok = bus_data_ok && (owner == OWNER_INST);
        data.addr_ok = bus_addr_ok && (owner == OWNER_DATA);
        data.data_ok = bus_data_ok && (owner == OWNER_DATA);
        inst.rdata   = mem.rdata;
        data.rdata   = mem.rdata;
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: per-cycle vector table plus a starvation sequence.
module tb_sram_bus_arbiter;

    localparam int STARVE = 4;

    typedef struct {
        string       name;
        logic        rst;
        logic        ireq;
        logic        dreq;
        logic        dwr;
        logic        maok;
        logic        mdok;
        logic [31:0] rd;
        logic        e_mreq;
        logic [31:0] e_maddr;
        logic        e_mwr;
        logic        e_iaok;
        logic        e_idok;
        logic        e_daok;
        logic        e_ddok;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic auto_mem = 1'b0;
    logic maok_drv = 1'b0;
    logic mdok_drv = 1'b0;
    int   n_vec = 0;
    int   miscompares = 0;
    logic i_pend = 1'b0;
    logic d_pend = 1'b0;
    vec_t vecs[$];

    sram_bus_arbiter_if inst_bus ();
    sram_bus_arbiter_if data_bus ();
    sram_bus_arbiter_if mem_bus ();

    assign mem_bus.addr_ok = auto_mem ? mem_bus.req : maok_drv;
    assign mem_bus.data_ok = auto_mem ? mem_bus.req : mdok_drv;

    sram_bus_arbiter #(.STARVE_LIMIT(STARVE)) dut (
        .clk   (clk),
        .reset (reset),
        .inst  (inst_bus),
        .data  (data_bus),
        .mem   (mem_bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic rst, ireq, dreq, dwr, maok, mdok,
                                input logic [31:0] rd, input logic ereq, input logic [31:0] eaddr,
                                input logic ewr, eia, eid, eda, edd);
        vec_t v;
        v.name = n; v.rst = rst; v.ireq = ireq; v.dreq = dreq; v.dwr = dwr;
        v.maok = maok; v.mdok = mdok; v.rd = rd; v.e_mreq = ereq; v.e_maddr = eaddr;
        v.e_mwr = ewr; v.e_iaok = eia; v.e_idok = eid; v.e_daok = eda; v.e_ddok = edd;
        return v;
    endfunction

    // A requester must hold req until its addr_ok; reset excuses an abandoned request.
    always @(negedge clk) begin
        if (!reset && i_pend && !inst_bus.req) begin
            miscompares++;
            $display("FAIL protocol_inst_drop: got req=0, want req=1 until addr_ok");
        end
        if (!reset && d_pend && !data_bus.req) begin
            miscompares++;
            $display("FAIL protocol_data_drop: got req=0, want req=1 until addr_ok");
        end
        i_pend = !reset && inst_bus.req && !inst_bus.addr_ok;
        d_pend = !reset && data_bus.req && !data_bus.addr_ok;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_strb, exp_wdata, got_grant, exp_grant;
        int          grants;

        inst_bus.req = 1'b0; inst_bus.wr = 1'b0; inst_bus.wstrb = 4'h0;
        inst_bus.addr = 32'h1C00_0000; inst_bus.wdata = 32'h0;
        data_bus.req = 1'b0; data_bus.wr = 1'b0; data_bus.wstrb = 4'hF;
        data_bus.addr = 32'h0000_1000; data_bus.wdata = 32'hDEAD_BEEF;
        mem_bus.rdata = 32'h0;

        //           name           rst i d dw ao do rdata         mreq maddr         mwr ia id da dd
        vecs.push_back(mk("rst",        1, 0,0,0, 0,0, 32'h0,        0, 32'h0,        0, 0,0,0,0));
        vecs.push_back(mk("i_idle",     0, 1,0,0, 0,0, 32'h0,        0, 32'h0,        0, 0,0,0,0));
        vecs.push_back(mk("i_req1",     0, 1,0,0, 0,0, 32'h0,        1, 32'h1C000000, 0, 0,0,0,0));
        vecs.push_back(mk("i_req2",     0, 1,0,0, 0,0, 32'h0,        1, 32'h1C000000, 0, 0,0,0,0));
        vecs.push_back(mk("i_aok",      0, 1,0,0, 1,0, 32'h0,        1, 32'h1C000000, 0, 1,0,0,0));
        vecs.push_back(mk("i_resp1",    0, 0,0,0, 0,0, 32'h0,        0, 32'h0,        0, 0,0,0,0));
        vecs.push_back(mk("i_resp2",    0, 0,0,0, 0,0, 32'h0,        0, 32'h0,        0, 0,0,0,0));
        vecs.push_back(mk("i_dok",      0, 0,0,0, 0,1, 32'h02800C0C, 0, 32'h0,        0, 0,1,0,0));
        vecs.push_back(mk("i_after",    0, 0,0,0, 0,0, 32'h0,        0, 32'h0,        0, 0,0,0,0));
        vecs.push_back(mk("stray_dok",  0, 0,0,0, 0,1, 32'h55AA55AA, 0, 32'h0,        0, 0,0,0,0));
        vecs.push_back(mk("both_idle",  0, 1,1,1, 0,0, 32'h0,        0, 32'h0,        0, 0,0,0,0));
        vecs.push_back(mk("d_first",    0, 1,1,1, 1,1, 32'hCAFEF00D, 1, 32'h00001000, 1, 0,0,1,1));
        vecs.push_back(mk("i_next_idle",0, 1,0,0, 0,0, 32'h0,        0, 32'h0,        0, 0,0,0,0));
        vecs.push_back(mk("i_next_aok", 0, 1,0,0, 1,0, 32'h0,        1, 32'h1C000000, 0, 1,0,0,0));
        vecs.push_back(mk("i_resp",     0, 0,0,0, 0,0, 32'h0,        0, 32'h0,        0, 0,0,0,0));
        vecs.push_back(mk("rst_resp",   1, 0,0,0, 0,1, 32'h0,        0, 32'h0,        0, 0,0,0,0));
        vecs.push_back(mk("post_rst",   0, 0,0,0, 0,1, 32'h0,        0, 32'h0,        0, 0,0,0,0));
        vecs.push_back(mk("fresh_idle", 0, 1,0,0, 0,0, 32'h0,        0, 32'h0,        0, 0,0,0,0));
        vecs.push_back(mk("fresh_done", 0, 1,0,0, 1,1, 32'h12345678, 1, 32'h1C000000, 0, 1,1,0,0));
        vecs.push_back(mk("fresh_after",0, 0,0,0, 0,0, 32'h0,        0, 32'h0,        0, 0,0,0,0));

        repeat (2) @(posedge clk);

        foreach (vecs[k]) begin
            @(posedge clk); #1;
            reset         = vecs[k].rst;
            inst_bus.req  = vecs[k].ireq;
            data_bus.req  = vecs[k].dreq;
            data_bus.wr   = vecs[k].dwr;
            maok_drv      = vecs[k].maok;
            mdok_drv      = vecs[k].mdok;
            mem_bus.rdata = vecs[k].rd;
            @(negedge clk);
            n_vec++;
            check({vecs[k].name, ".mem_req"},  32'(mem_bus.req),      32'(vecs[k].e_mreq));
            if (vecs[k].e_mreq) begin
                exp_strb  = (vecs[k].e_maddr == 32'h1000) ? 32'hF : 32'h0;
                exp_wdata = (vecs[k].e_maddr == 32'h1000) ? 32'hDEADBEEF : 32'h0;
                check({vecs[k].name, ".mem_addr"},  mem_bus.addr,         vecs[k].e_maddr);
                check({vecs[k].name, ".mem_wr"},    32'(mem_bus.wr),      32'(vecs[k].e_mwr));
                check({vecs[k].name, ".mem_wstrb"}, 32'(mem_bus.wstrb),   exp_strb);
                check({vecs[k].name, ".mem_wdata"}, mem_bus.wdata,        exp_wdata);
            end
            check({vecs[k].name, ".inst_addr_ok"}, 32'(inst_bus.addr_ok), 32'(vecs[k].e_iaok));
            check({vecs[k].name, ".inst_data_ok"}, 32'(inst_bus.data_ok), 32'(vecs[k].e_idok));
            check({vecs[k].name, ".data_addr_ok"}, 32'(data_bus.addr_ok), 32'(vecs[k].e_daok));
            check({vecs[k].name, ".data_data_ok"}, 32'(data_bus.data_ok), 32'(vecs[k].e_ddok));
            check({vecs[k].name, ".inst_rdata"},   inst_bus.rdata,        vecs[k].rd);
            check({vecs[k].name, ".data_rdata"},   data_bus.rdata,        vecs[k].rd);
        end

        // Starvation: both requesters held, memory completes each request in its REQ cycle.
        @(posedge clk); #1;
        maok_drv = 1'b0; mdok_drv = 1'b0; mem_bus.rdata = 32'h0;
        data_bus.wr = 1'b0; auto_mem = 1'b1;
        inst_bus.req = 1'b1; data_bus.req = 1'b1;
        grants = 0;
        for (int cyc = 0; cyc < 200 && grants < 10; cyc++) begin
            @(negedge clk);
            check($sformatf("starve_cnt_le_limit[%0d]", cyc), 32'(dut.starve_cnt <= STARVE), 32'h1);
            if (mem_bus.req) begin
                got_grant = inst_bus.addr_ok ? 32'h1 : (data_bus.addr_ok ? 32'h2 : 32'h0);
                exp_grant = (grants % 5 == 4) ? 32'h1 : 32'h2;
                n_vec++;
                check($sformatf("starve_grant[%0d] (1=I 2=D)", grants), got_grant, exp_grant);
                check($sformatf("starve_mem_addr[%0d]", grants), mem_bus.addr,
                      (exp_grant == 32'h1) ? 32'h1C000000 : 32'h00001000);
                grants++;
            end
        end
        if (grants < 10) check("starve_grant_budget", 32'(grants), 32'd10);

        @(posedge clk); #1;
        reset = 1'b1; auto_mem = 1'b0;
        inst_bus.req = 1'b0; data_bus.req = 1'b0;
        @(negedge clk);
        n_vec++;
        check("final_rst.mem_req", 32'(mem_bus.req), 32'h0);
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
        $finish;
    end

endmodule

// File: doc/sram_bus_arbiter.md
SRAM_BUS_ARBITER -- requirements
Module: sram_bus_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, SHALL set the number of consecutive data grants allowed while inst_req is pending.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  in  1  SHALL be a synchronous, active-high reset.
REQ-004 inst_req, data_req  in  1  SHALL be requester transaction requests, held with payload stable until the matching addr_ok.
REQ-005 inst_wr, data_wr  in  1  SHALL mean 1=write, 0=read.
REQ-006 inst_wstrb, data_wstrb  in  4  SHALL be the byte write strobes.
REQ-007 inst_addr, data_addr  in  32  SHALL be the byte addresses.
REQ-008 inst_wdata, data_wdata  in  32  SHALL be the write data.
REQ-009 inst_addr_ok, data_addr_ok  out  1  SHALL mean the request was accepted by memory.
REQ-010 inst_data_ok, data_data_ok  out  1  SHALL mean the transaction completed; rdata is valid this cycle.
REQ-011 inst_rdata, data_rdata  out  32  SHALL be the read data.
REQ-012 mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata  out  1/1/4/32/32  SHALL form the shared memory request port.
REQ-013 mem_addr_ok, mem_data_ok, mem_rdata  in  1/1/32  SHALL form the shared memory handshake and response.

Function
REQ-014 FSM states SHALL be IDLE, REQ (mem_req=1, awaiting mem_addr_ok) and RESP (awaiting mem_data_ok); at most one transaction SHALL be outstanding.
REQ-015 In IDLE with any request, the arbiter SHALL register the owner (INST/DATA) and enter REQ; mem_req SHALL rise the cycle after the first sampled request.
REQ-016 Default priority SHALL be data over inst, except starve_cnt==STARVE_LIMIT with inst_req=1 SHALL grant inst.
REQ-017 starve_cnt SHALL increment (saturating at STARVE_LIMIT) on each data grant while inst_req=1, and SHALL clear on any inst grant or on a data grant with inst_req=0.
REQ-018 In REQ, the mem_* payload SHALL be the owner's inputs passed through combinationally, and owner addr_ok SHALL equal mem_addr_ok.
REQ-019 REQ with mem_addr_ok=1, mem_data_ok=0 SHALL go to RESP; REQ with both =1 SHALL assert owner data_ok that cycle and go to IDLE.
REQ-020 In RESP, mem_data_ok=1 SHALL assert owner data_ok that cycle and go to IDLE; mem_req SHALL be 0 throughout RESP.
REQ-021 inst_rdata and data_rdata SHALL both equal mem_rdata; only the owner's data_ok SHALL assert.
REQ-022 Non-owner addr_ok and data_ok SHALL be 0 in all states; mem_data_ok in IDLE SHALL be ignored.
REQ-023 Completion SHALL always return to IDLE, giving minimum 2 cycles between consecutive mem_req assertions.
REQ-024 A requester dropping req before addr_ok is a protocol violation; behaviour is unspecified, and the bench SHALL flag it.

Reset
REQ-025 While reset=1: state=IDLE, owner=DATA, starve_cnt=0; all *_addr_ok, *_data_ok and mem_req SHALL be 0.
REQ-026 Reset mid-transaction SHALL abandon it without asserting data_ok; memory shares the same reset.

Structure
REQ-027 Shared package cpu_bus_pkg SHALL hold the FSM state enum, the owner encoding and bus-width constants (ADDR_W=32, DATA_W=32, STRB_W=4).
REQ-028 Single module, no sub-module; the priority pick SHALL be inline combinational logic.

Verification
REQ-029 Inst read 0x1C000000 only; mem_addr_ok after 2 cycles, mem_data_ok 3 cycles later with rdata=0x02800C0C -> inst_data_ok one cycle, inst_rdata=0x02800C0C, data_* handshakes 0.
REQ-030 inst_req and data_req (write 0x00001000, wstrb=0xF, wdata=0xDEADBEEF) in the same cycle -> data granted first with mem_addr=0x1000, mem_wr=1; inst granted next.
REQ-031 Both requests held continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,I repeating; starve_cnt never exceeds 4.
REQ-032 REQ cycle with mem_addr_ok=1 and mem_data_ok=1 -> owner addr_ok and data_ok both 1 same cycle; next state IDLE.
REQ-033 reset=1 pulsed during RESP -> all outputs 0 next cycle; no data_ok; fresh inst_req after reset served normally.
REQ-034 Stray mem_data_ok=1 in IDLE -> no data_ok on either side; state stays IDLE.
